// File: rtl/apb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// apb_cmd_sequencer
//
// Purpose:
//   Command stage in front of the APB bridge. Host read/write commands are
//   queued in a small FIFO and issued one at a time on the bridge's
//   transfer/write_read/addr/wdata inputs. The APB bus is monitored for
//   completion (PSEL & PENABLE & PREADY) or a timeout. Exactly one response
//   pulse is returned per command, in command order.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o host command handshake (push = valid & ready)
//   cmd_write_i             1 = write, 0 = read
//   cmd_addr_i, cmd_wdata_i command address / write data
//   rsp_valid_o             one-cycle pulse per completed command
//   rsp_rdata_o, rsp_err_o  read data (0 for writes/timeouts), error flag
//   level_o                 FIFO occupancy
//   busy_o                  sequencer FSM not idle
//   transfer_o, write_read_o, addr_o, wdata_o   request to the bridge
//   rdata_i                 read result from the bridge
//   psel_i, penable_i, pready_i, pslverr_i      APB bus monitor taps
// ---------------------------------------------------------------------------
module apb_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [AW-1:0]             cmd_addr_i,
   input  logic [DW-1:0]             cmd_wdata_i,
   output logic                      rsp_valid_o,
   output logic [DW-1:0]             rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic [$clog2(DEPTH):0]    level_o,
   output logic                      busy_o,
   output logic                      transfer_o,
   output logic                      write_read_o,
   output logic [AW-1:0]             addr_o,
   output logic [DW-1:0]             wdata_o,
   input  logic [DW-1:0]             rdata_i,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(TIMEOUT);
   localparam int EW = 1 + AW + DW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic          cmd_ready_q;
   logic          push, pop;

   state_t        state_q, state_d;

   assign push = cmd_valid_i & cmd_ready_q;
   // The head entry is retired only as the FSM leaves DONE.
   assign pop  = (state_q == S_DONE);

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Storage has no reset: pointer reset is what discards queued commands.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_write_i, cmd_addr_i, cmd_wdata_i};
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         cmd_ready_q <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q     <= level_d;
         // Registered copy of (level != DEPTH), computed from next level.
         cmd_ready_q <= (level_d != LW'(DEPTH));
      end
   end

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   logic          transfer_q, transfer_d;
   logic          write_read_q, write_read_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout;
   logic          apb_done;

   assign timeout  = (cnt_q == CW'(TIMEOUT - 1));
   assign apb_done = psel_i & penable_i & pready_i;

   always_comb begin
      state_d      = state_q;
      transfer_d   = transfer_q;
      write_read_d = write_read_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      cnt_d        = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (level_q != '0) begin
               state_d = S_ISSUE;
               {write_read_d, addr_d, wdata_d} = mem_q[rd_ptr_q];
               transfer_d = 1'b1;
               cnt_d      = '0;
            end
         end

         S_ISSUE: begin
            cnt_d = cnt_q + CW'(1);
            // Timeout wins over a late PSEL: no completion has been seen.
            if (timeout) begin
               state_d     = S_DONE;
               transfer_d  = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else if (psel_i) begin
               state_d    = S_WAIT;
               transfer_d = 1'b0;
            end
         end

         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // A completion in the last allowed cycle still counts as success.
            if (apb_done) begin
               state_d     = S_DONE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = pslverr_i;
               rsp_rdata_d = write_read_q ? '0 : rdata_i;
            end else if (timeout) begin
               state_d     = S_DONE;
               transfer_d  = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         transfer_q   <= 1'b0;
         write_read_q <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         transfer_q   <= transfer_d;
         write_read_q <= write_read_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign cmd_ready_o  = cmd_ready_q;
   assign level_o      = level_q;
   assign busy_o       = (state_q != S_IDLE);
   assign transfer_o   = transfer_q;
   assign write_read_o = write_read_q;
   assign addr_o       = addr_q;
   assign wdata_o      = wdata_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign rsp_err_o    = rsp_err_q;

endmodule
